// File: rtl/run_controller.sv
// Run controller: issues one-cycle cpu_enable strobes for manual step, divided auto-run and PC breakpoint halt.
// Optional cycle-limit breakpoint is compiled in when RUN_CONTROLLER_CYCLE_LIMIT_EN is defined.
module run_controller #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PC_WIDTH        = 32,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step_button,
  input  logic                   run_mode,
  input  logic                   halt_request,
  input  logic                   breakpoint_enable,
  input  logic [PC_WIDTH-1:0]    breakpoint_address,
  input  logic [PC_WIDTH-1:0]    PC,
  output logic                   cpu_enable,
  output logic                   register_reset,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [1:0]             state,
  output logic                   halted
`ifdef RUN_CONTROLLER_CYCLE_LIMIT_EN
  ,
  input  logic [COUNT_WIDTH-1:0] cycle_limit
`endif
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'b00,
    S_IDLE       = 2'b01,
    S_RUN        = 2'b10,
    S_BREAK      = 2'b11
  } state_t;

  state_t            state_q;
  logic [1:0]        sync;
  logic              accepted;
  logic [DB_W-1:0]   db_count;
  logic [TICK_W-1:0] tick_count;
  logic              step_event;
  logic              tick_hit;
  logic              bp_hit;
  logic              limit_hit;

  // Synchronize the raw button and accept a new level only after it has been stable long enough.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync     <= 2'b00;
      accepted <= 1'b0;
      db_count <= '0;
    end else begin
      sync <= {sync[0], step_button};
      if (sync[1] == accepted) begin
        db_count <= '0;
      end else if (db_count == DB_LAST) begin
        accepted <= sync[1];
        db_count <= '0;
      end else begin
        db_count <= db_count + DB_W'(1);
      end
    end
  end

  // The event fires in the cycle the accepted level is about to rise, so it lasts exactly one cycle.
  assign step_event = sync[1] & ~accepted & (db_count == DB_LAST);
  assign tick_hit   = (tick_count == TICK_LAST);
  assign bp_hit     = breakpoint_enable & (PC == breakpoint_address);

`ifdef RUN_CONTROLLER_CYCLE_LIMIT_EN
  assign limit_hit = (cycle_limit != '0) & (cycle_count == cycle_limit);
`else
  assign limit_hit = 1'b0;
`endif

  assign state = state_q;

  // Sequencer: mode transitions, strobe generation, tick divider and executed-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_RESET_HOLD;
      cpu_enable     <= 1'b0;
      register_reset <= 1'b1;
      cycle_count    <= '0;
      halted         <= 1'b0;
      tick_count     <= '0;
    end else begin
      cpu_enable     <= 1'b0;
      register_reset <= 1'b0;
      halted         <= 1'b0;
      case (state_q)
        S_RESET_HOLD: begin
          tick_count <= '0;
          state_q    <= run_mode ? S_RUN : S_IDLE;
        end
        S_IDLE: begin
          if (step_event) begin
            cpu_enable  <= 1'b1;
            cycle_count <= cycle_count + COUNT_WIDTH'(1);
          end
          if (run_mode) begin
            state_q    <= S_RUN;
            tick_count <= '0;
          end
        end
        S_RUN: begin
          tick_count <= tick_hit ? '0 : tick_count + TICK_W'(1);
          if (!run_mode || halt_request) begin
            state_q <= S_IDLE;
          end else if (tick_hit) begin
            if (bp_hit || limit_hit) begin
              state_q <= S_BREAK;
              halted  <= 1'b1;
            end else begin
              cpu_enable  <= 1'b1;
              cycle_count <= cycle_count + COUNT_WIDTH'(1);
            end
          end
        end
        S_BREAK: begin
          if (step_event) begin
            // Step over the breakpoint; the next auto tick is a full period away.
            cpu_enable  <= 1'b1;
            cycle_count <= cycle_count + COUNT_WIDTH'(1);
            tick_count  <= '0;
            state_q     <= (run_mode && !halt_request) ? S_RUN : S_IDLE;
          end else if (!run_mode || halt_request) begin
            state_q <= S_IDLE;
          end else begin
            halted <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RESET_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller (TICK_DIV=4, DEBOUNCE_CYCLES=3, COUNT_WIDTH=4 for fast wrap).
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step_button = 1'b0;
  logic        run_mode = 1'b0;
  logic        halt_request = 1'b0;
  logic        breakpoint_enable = 1'b0;
  logic [31:0] breakpoint_address = 32'h0;
  logic [31:0] PC = 32'h0;
  logic        cpu_enable;
  logic        register_reset;
  logic [3:0]  cycle_count;
  logic [1:0]  state;
  logic        halted;
`ifdef RUN_CONTROLLER_CYCLE_LIMIT_EN
  logic [3:0]  cycle_limit = 4'h0;
`endif

  int   checks = 0;
  int   failures = 0;
  int   pulses;
  int   at;
  int   last;
  int   viol = 0;
  logic [1:0] st_at;
  logic prev_en = 1'b0;

  run_controller #(
    .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .PC_WIDTH(32), .COUNT_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset), .step_button(step_button), .run_mode(run_mode),
    .halt_request(halt_request), .breakpoint_enable(breakpoint_enable),
    .breakpoint_address(breakpoint_address), .PC(PC), .cpu_enable(cpu_enable),
    .register_reset(register_reset), .cycle_count(cycle_count), .state(state),
    .halted(halted)
`ifdef RUN_CONTROLLER_CYCLE_LIMIT_EN
    , .cycle_limit(cycle_limit)
`endif
  );

  always #5 clock = ~clock;

  // Strobe must never be high on two consecutive cycles, nor while in RESET_HOLD.
  always @(negedge clock) begin
    if (cpu_enable && (prev_en || state == 2'b00)) viol++;
    prev_en = cpu_enable;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic watch(input int n);
    pulses = 0; at = 0; last = 0; st_at = 2'b00;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (cpu_enable) begin
        pulses++;
        last = i;
        if (at == 0) begin
          at = i;
          st_at = state;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_regrst", 32'(register_reset), 32'h1);
    chk("rst_en", 32'(cpu_enable), 32'h0);
    chk("rst_count", 32'(cycle_count), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;
    #1;
    chk("hold_regrst", 32'(register_reset), 32'h1);
    cyc(1);
    chk("hold_done_regrst", 32'(register_reset), 32'h0);
    chk("idle_state", 32'(state), 32'h1);
    chk("idle_count", 32'(cycle_count), 32'h0);

    // Manual step: held button gives one strobe 5 cycles after press
    step_button = 1'b1;
    watch(10);
    chk("step_pulses", 32'(pulses), 32'd1);
    chk("step_latency", 32'(at), 32'd5);
    chk("step_count", 32'(cycle_count), 32'h1);
    step_button = 1'b0;
    watch(10);
    chk("release_pulses", 32'(pulses), 32'd0);
    step_button = 1'b1;
    cyc(2);
    step_button = 1'b0;
    watch(10);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_count", 32'(cycle_count), 32'h1);

    // Auto-run: strobes every 4 cycles
    run_mode = 1'b1;
    watch(21);
    chk("run_state", 32'(state), 32'h2);
    chk("run_pulses", 32'(pulses), 32'd5);
    chk("run_first", 32'(at), 32'd5);
    chk("run_last", 32'(last), 32'd21);
    chk("run_count", 32'(cycle_count), 32'h6);
    cyc(3);
    run_mode = 1'b0;
    cyc(1);
    chk("drop_on_tick_en", 32'(cpu_enable), 32'h0);
    chk("drop_on_tick_state", 32'(state), 32'h1);
    chk("drop_on_tick_count", 32'(cycle_count), 32'h6);

    // Breakpoint
    PC = 32'h08; breakpoint_address = 32'h0C; breakpoint_enable = 1'b1; run_mode = 1'b1;
    watch(5);
    chk("bp_miss_pulses", 32'(pulses), 32'd1);
    PC = 32'h0C;
    watch(4);
    chk("bp_hit_pulses", 32'(pulses), 32'd0);
    chk("bp_state", 32'(state), 32'h3);
    chk("bp_halted", 32'(halted), 32'h1);
    chk("bp_count", 32'(cycle_count), 32'h7);
    watch(3);
    chk("bp_stay_pulses", 32'(pulses), 32'd0);
    chk("bp_stay_state", 32'(state), 32'h3);
    step_button = 1'b1;
    watch(10);
    chk("bp_step_pulses", 32'(pulses), 32'd1);
    chk("bp_step_latency", 32'(at), 32'd5);
    chk("bp_step_to_run", 32'(st_at), 32'h2);
    chk("bp_rehit_state", 32'(state), 32'h3);
    chk("bp_step_count", 32'(cycle_count), 32'h8);
    step_button = 1'b0;
    cyc(8);
    halt_request = 1'b1;
    cyc(1);
    chk("halt_break_state", 32'(state), 32'h1);
    chk("halt_break_halted", 32'(halted), 32'h0);
    halt_request = 1'b0; run_mode = 1'b0;
    cyc(1);
    chk("idle_after_halt", 32'(state), 32'h1);

    // Counter wrap (4-bit counter)
    breakpoint_enable = 1'b0; run_mode = 1'b1;
    watch(29);
    chk("wrap_pre_pulses", 32'(pulses), 32'd7);
    chk("wrap_pre_count", 32'(cycle_count), 32'hF);
    watch(4);
    chk("wrap_pulse", 32'(pulses), 32'd1);
    chk("wrap_count", 32'(cycle_count), 32'h0);
    halt_request = 1'b1;
    cyc(1);
    chk("halt_run_state", 32'(state), 32'h1);
    run_mode = 1'b0; halt_request = 1'b0;

    // Reset during a strobe, button held through reset
    step_button = 1'b1;
    cyc(5);
    chk("pre_reset_en", 32'(cpu_enable), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_en", 32'(cpu_enable), 32'h0);
    chk("midrst_count", 32'(cycle_count), 32'h0);
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_regrst", 32'(register_reset), 32'h1);
    cyc(2);
    reset = 1'b0;
    watch(8);
    chk("post_rst_pulses", 32'(pulses), 32'd1);
    chk("post_rst_latency", 32'(at), 32'd5);
    chk("post_rst_count", 32'(cycle_count), 32'h1);
    step_button = 1'b0;
    cyc(8);

`ifdef RUN_CONTROLLER_CYCLE_LIMIT_EN
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    cycle_limit = 4'd3; run_mode = 1'b1;
    watch(20);
    chk("limit_pulses", 32'(pulses), 32'd3);
    chk("limit_state", 32'(state), 32'h3);
    chk("limit_count", 32'(cycle_count), 32'h3);
    halt_request = 1'b1;
    cyc(1);
    halt_request = 1'b0; cycle_limit = 4'd0;
    watch(21);
    chk("nolimit_pulses", 32'(pulses), 32'd5);
    chk("nolimit_count", 32'(cycle_count), 32'h8);
    run_mode = 1'b0;
    cyc(2);
`endif

    chk("no_back_to_back", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
